barker_spreader: RTL and testbench

BARKER_SPREADER -- requirements
Module: barker_spreader

---
 rtl/barker_spreader_if.sv | 29 ++
 rtl/barker_spreader.sv | 202 ++++++++++++++++++++
 tb/tb_barker_spreader.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/barker_spreader_if.sv
// Barker spreader signal bundle: chip strobe, burst control, data handshake
// and the registered chip stream.
interface barker_spreader_if;
    logic       en_p;
    logic       start;
    logic       stop;
    logic [2:0] code_sel;
    logic       data_in;
    logic       data_valid;
    logic       data_ready;
    logic       chip_out;
    logic       chip_valid;
    logic       sym_first;
    logic       sym_last;
    logic       busy;
    logic [3:0] code_len;

    // Driving side (stimulus / upstream logic).
    modport master (
        output en_p, start, stop, code_sel, data_in, data_valid,
        input  data_ready, chip_out, chip_valid, sym_first, sym_last, busy, code_len
    );

    // Spreader side.
    modport slave (
        input  en_p, start, stop, code_sel, data_in, data_valid,
        output data_ready, chip_out, chip_valid, sym_first, sym_last, busy, code_len
    );
endinterface

// File: rtl/barker_spreader.sv
// Barker-code direct-sequence spreader. After start it sends PREAMBLE_REPS
// unmodulated code words, then spreads each accepted data bit over one code
// word, emitting one chip per en_p strobe. stop ends the burst cleanly at a
// word boundary.
module barker_spreader #(
    parameter int unsigned PREAMBLE_REPS = 2,
    parameter logic [2:0]  DEFAULT_SEL   = 3'd4
) (
    input  logic             clk_sig,
    input  logic             rst_n,
    barker_spreader_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, PREAMBLE = 2'd1, DATA = 2'd2} state_t;

    localparam logic [3:0] REPS = 4'(PREAMBLE_REPS);

    function automatic logic [3:0] len_of(input logic [2:0] sel);
        case (sel)
            3'd0:    return 4'd2;
            3'd1:    return 4'd3;
            3'd2:    return 4'd4;
            3'd3:    return 4'd5;
            3'd5:    return 4'd11;
            3'd6:    return 4'd13;
            default: return 4'd7;
        endcase
    endfunction

    // Codes are left-aligned so the current chip is always bit 12 of the
    // word shifter, whatever the code length.
    function automatic logic [12:0] bits_of(input logic [2:0] sel);
        case (sel)
            3'd0:    return 13'b10_00000000000;
            3'd1:    return 13'b110_0000000000;
            3'd2:    return 13'b1101_000000000;
            3'd3:    return 13'b11101_00000000;
            3'd5:    return 13'b11100010010_00;
            3'd6:    return 13'b1111100110101;
            default: return 13'b1110010_000000;
        endcase
    endfunction

    state_t      state, state_next;
    logic [3:0]  idx, idx_next;
    logic        word_active, word_active_next;
    logic        stop_pend, stop_pend_next;
    logic [3:0]  pre_cnt, pre_cnt_next;
    logic [12:0] code_bits, code_bits_next;
    logic        word_data, word_data_next;
    logic [3:0]  code_len, code_len_next;
    logic        chip_out, chip_out_next;
    logic        chip_valid, chip_valid_next;
    logic        sym_first, sym_first_next;
    logic        sym_last, sym_last_next;

    logic        emit;
    logic        last_chip;
    logic        word_done;
    logic        ready;
    logic        accept;
    logic        load;
    logic        load_data;

    assign emit      = bus.en_p && word_active;
    assign last_chip = (idx == code_len - 4'd1);
    assign word_done = emit && last_chip;
    // A new data word may be taken while idle in DATA or on the edge that
    // sends the final chip of the current word, giving gapless words.
    assign ready     = (state == DATA) && !stop_pend && (!word_active || word_done);
    assign accept    = ready && bus.data_valid;

    assign bus.data_ready = ready;
    assign bus.chip_out   = chip_out;
    assign bus.chip_valid = chip_valid;
    assign bus.sym_first  = sym_first;
    assign bus.sym_last   = sym_last;
    assign bus.busy       = (state != IDLE);
    assign bus.code_len   = code_len;

    // Next-state logic: chip emission, burst sequencing and word loading.
    always_comb begin
        state_next       = state;
        idx_next         = idx;
        word_active_next = word_active;
        stop_pend_next   = stop_pend;
        pre_cnt_next     = pre_cnt;
        code_bits_next   = code_bits;
        word_data_next   = word_data;
        code_len_next    = code_len;
        chip_out_next    = chip_out;
        chip_valid_next  = 1'b0;
        sym_first_next   = 1'b0;
        sym_last_next    = 1'b0;
        load             = 1'b0;
        load_data        = 1'b0;

        if (emit) begin
            // A zero data bit sends the inverted code.
            chip_out_next   = ~(code_bits[12] ^ word_data);
            chip_valid_next = 1'b1;
            sym_first_next  = (idx == 4'd0);
            sym_last_next   = last_chip;
            code_bits_next  = {code_bits[11:0], 1'b0};
            if (last_chip) begin
                idx_next         = 4'd0;
                word_active_next = 1'b0;
            end else begin
                idx_next = idx + 4'd1;
            end
        end

        case (state)
            IDLE: begin
                // stop is meaningless here, even alongside start.
                if (bus.start) begin
                    if (REPS != 4'd0) begin
                        state_next   = PREAMBLE;
                        load         = 1'b1;
                        load_data    = 1'b1;
                        pre_cnt_next = 4'd1;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            PREAMBLE: begin
                if (bus.stop) begin
                    stop_pend_next = 1'b1;
                end
                if (word_done) begin
                    if (pre_cnt < REPS) begin
                        load         = 1'b1;
                        load_data    = 1'b1;
                        pre_cnt_next = pre_cnt + 4'd1;
                    end else begin
                        pre_cnt_next   = 4'd0;
                        stop_pend_next = 1'b0;
                        state_next     = (stop_pend || bus.stop) ? IDLE : DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    // An accept beats a simultaneous stop; the word still goes out.
                    load      = 1'b1;
                    load_data = bus.data_in;
                    if (bus.stop) begin
                        stop_pend_next = 1'b1;
                    end
                end else if (bus.stop || stop_pend) begin
                    if (!word_active || word_done) begin
                        state_next     = IDLE;
                        stop_pend_next = 1'b0;
                    end else begin
                        stop_pend_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // code_sel is only looked at here, so mid-word changes are harmless.
        if (load) begin
            code_bits_next   = bits_of(bus.code_sel);
            code_len_next    = len_of(bus.code_sel);
            word_data_next   = load_data;
            idx_next         = 4'd0;
            word_active_next = 1'b1;
        end
    end

    // State and output registers; reset aborts any word in flight.
    always_ff @(posedge clk_sig or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= 4'd0;
            word_active <= 1'b0;
            stop_pend   <= 1'b0;
            pre_cnt     <= 4'd0;
            code_bits   <= 13'd0;
            word_data   <= 1'b0;
            code_len    <= len_of(DEFAULT_SEL);
            chip_out    <= 1'b0;
            chip_valid  <= 1'b0;
            sym_first   <= 1'b0;
            sym_last    <= 1'b0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            word_active <= word_active_next;
            stop_pend   <= stop_pend_next;
            pre_cnt     <= pre_cnt_next;
            code_bits   <= code_bits_next;
            word_data   <= word_data_next;
            code_len    <= code_len_next;
            chip_out    <= chip_out_next;
            chip_valid  <= chip_valid_next;
            sym_first   <= sym_first_next;
            sym_last    <= sym_last_next;
        end
    end
endmodule

// File: tb/tb_barker_spreader.sv
// Self-checking bench for barker_spreader: a chip-queue reference model is
// stepped every cycle alongside the DUT, plus table vectors, directed corner
// sequences and a second instance with a three-word preamble.
module tb_barker_spreader;
    localparam int REPS = 2;

    logic clk_sig = 1'b0;
    logic rst_n;
    always #5 clk_sig = ~clk_sig;

    barker_spreader_if bus ();
    barker_spreader_if bus3 ();

    barker_spreader #(.PREAMBLE_REPS(REPS), .DEFAULT_SEL(3'd4)) dut (
        .clk_sig (clk_sig),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    barker_spreader #(.PREAMBLE_REPS(3), .DEFAULT_SEL(3'd4)) dut3 (
        .clk_sig (clk_sig),
        .rst_n   (rst_n),
        .bus     (bus3)
    );

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_PRE, M_DATA} mmode_t;
    mmode_t     m_mode;
    logic       m_q[$];          // chips still to send for the current word
    int         m_pos;
    int         m_pre_left;
    bit         m_stop;
    logic       e_valid, e_chip, e_first, e_last, e_busy;
    logic [3:0] e_len;

    int unsigned code_len_tab [8] = '{2, 3, 4, 5, 7, 11, 13, 7};
    logic [12:0] code_pat_tab [8] = '{13'b10, 13'b110, 13'b1101, 13'b11101,
                                      13'b1110010, 13'b11100010010,
                                      13'b1111100110101, 13'b1110010};

    // captured chip stream
    logic cap_bits[$];
    logic cap_first[$];
    logic cap_last[$];
    time  cap_time[$];
    logic cap3[$];

    logic [2:0] wq_sel[$];
    logic       wq_din[$];

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkv(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out, got no completion, expected completion (t=%0t)", name, $time);
    endtask

    task automatic m_reset();
        m_mode     = M_IDLE;
        m_q.delete();
        m_pos      = 0;
        m_pre_left = 0;
        m_stop     = 0;
        e_valid    = 1'b0;
        e_chip     = 1'b0;
        e_first    = 1'b0;
        e_last     = 1'b0;
        e_busy     = 1'b0;
        e_len      = 4'd7;
    endtask

    task automatic m_load(input logic [2:0] sel, input logic d);
        int n;
        logic [12:0] p;
        n = int'(code_len_tab[sel]);
        p = code_pat_tab[sel];
        m_q.delete();
        for (int i = n - 1; i >= 0; i--) m_q.push_back(d ? p[i] : !p[i]);
        m_pos = 0;
        e_len = 4'(n);
    endtask

    function automatic bit m_ready(input logic en);
        return (m_mode == M_DATA) && !m_stop &&
               (m_q.size() == 0 || (en && m_q.size() == 1));
    endfunction

    task automatic m_edge(input logic en, input logic st, input logic sp,
                          input logic [2:0] sel, input logic din, input logic dv, input bit r);
        bit word_end;
        word_end = 0;
        e_valid  = 1'b0;
        e_first  = 1'b0;
        e_last   = 1'b0;
        if (en && m_q.size() > 0) begin
            e_chip   = m_q.pop_front();
            e_valid  = 1'b1;
            e_first  = (m_pos == 0);
            e_last   = (m_q.size() == 0);
            word_end = (m_q.size() == 0);
            m_pos++;
        end
        case (m_mode)
            M_IDLE: begin
                if (st) begin
                    if (REPS > 0) begin
                        m_mode = M_PRE;
                        m_load(sel, 1'b1);
                        m_pre_left = REPS - 1;
                    end else begin
                        m_mode = M_DATA;
                    end
                end
            end
            M_PRE: begin
                if (sp) m_stop = 1;
                if (word_end) begin
                    if (m_pre_left > 0) begin
                        m_load(sel, 1'b1);
                        m_pre_left--;
                    end else begin
                        m_mode = m_stop ? M_IDLE : M_DATA;
                        m_stop = 0;
                    end
                end
            end
            default: begin
                if (r && dv) begin
                    m_load(sel, din);
                    if (sp) m_stop = 1;
                end else if (sp || m_stop) begin
                    if (m_q.size() == 0) begin
                        m_mode = M_IDLE;
                        m_stop = 0;
                    end else begin
                        m_stop = 1;
                    end
                end
            end
        endcase
        e_busy = (m_mode != M_IDLE);
    endtask

    // One clock: drive inputs, check data_ready, advance model, check outputs.
    task automatic step(input logic en, input logic st, input logic sp,
                        input logic [2:0] sel, input logic din, input logic dv, output bit acc);
        bit r;
        bus.en_p       = en;
        bus.start      = st;
        bus.stop       = sp;
        bus.code_sel   = sel;
        bus.data_in    = din;
        bus.data_valid = dv;
        #1;
        r = m_ready(en);
        check1("data_ready", bus.data_ready, r);
        acc = r && dv;
        m_edge(en, st, sp, sel, din, dv, r);
        @(posedge clk_sig);
        #1;
        check1("chip_valid", bus.chip_valid, e_valid);
        check1("chip_out", bus.chip_out, e_chip);
        check1("sym_first", bus.sym_first, e_first);
        check1("sym_last", bus.sym_last, e_last);
        check1("busy", bus.busy, e_busy);
        checkv("code_len", 64'(bus.code_len), 64'(e_len));
        if (bus.chip_valid) begin
            cap_bits.push_back(bus.chip_out);
            cap_first.push_back(bus.sym_first);
            cap_last.push_back(bus.sym_last);
            cap_time.push_back($time);
        end
        if (e_valid && e_last)
            $display("word done: len=%0d last_chip=%b t=%0t", e_len, e_chip, $time);
    endtask

    task automatic clear_cap();
        cap_bits.delete();
        cap_first.delete();
        cap_last.delete();
        cap_time.delete();
    endtask

    function automatic logic [63:0] q2v(input logic q[$]);
        logic [63:0] v;
        v = '0;
        foreach (q[i]) v = {v[62:0], q[i]};
        return v;
    endfunction

    // Offer queued words back-to-back; en_p strobes once every 'period' cycles.
    task automatic drive_words(input int period, input bit stop_first);
        bit acc;
        int k;
        k = 0;
        while ((wq_sel.size() > 0 || m_q.size() > 0) && k < 300) begin
            if (wq_sel.size() > 0)
                step(((k % period) == period - 1), 1'b0, (k == 0) && stop_first,
                     wq_sel[0], wq_din[0], 1'b1, acc);
            else
                step(((k % period) == period - 1), 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, acc);
            if (acc) begin
                void'(wq_sel.pop_front());
                void'(wq_din.pop_front());
            end
            k++;
        end
        if (k >= 300) fail_timeout("drive_words");
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic        din;
        logic [3:0]  len;
        logic [12:0] pat;
    } vec_t;

    vec_t tab [8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int ti;
        bit saw_ready;
        bit done3;
        logic [63:0] expv;
        logic [12:0] mask;

        tab[0] = '{3'd0, 1'b0, 4'd2,  13'b10};
        tab[1] = '{3'd1, 1'b1, 4'd3,  13'b110};
        tab[2] = '{3'd2, 1'b0, 4'd4,  13'b1101};
        tab[3] = '{3'd3, 1'b1, 4'd5,  13'b11101};
        tab[4] = '{3'd4, 1'b0, 4'd7,  13'b1110010};
        tab[5] = '{3'd5, 1'b1, 4'd11, 13'b11100010010};
        tab[6] = '{3'd6, 1'b0, 4'd13, 13'b1111100110101};
        tab[7] = '{3'd7, 1'b1, 4'd7,  13'b1110010};

        rst_n = 1'b0;
        bus.en_p = 1'b0;  bus.start = 1'b0;  bus.stop = 1'b0;
        bus.code_sel = 3'd0;  bus.data_in = 1'b0;  bus.data_valid = 1'b0;
        bus3.en_p = 1'b0; bus3.start = 1'b0; bus3.stop = 1'b0;
        bus3.code_sel = 3'd0; bus3.data_in = 1'b0; bus3.data_valid = 1'b0;
        m_reset();
        repeat (2) @(posedge clk_sig);
        #1;

        // Reset state
        check1("rst_chip_out", bus.chip_out, 1'b0);
        check1("rst_chip_valid", bus.chip_valid, 1'b0);
        check1("rst_sym_first", bus.sym_first, 1'b0);
        check1("rst_sym_last", bus.sym_last, 1'b0);
        check1("rst_busy", bus.busy, 1'b0);
        check1("rst_data_ready", bus.data_ready, 1'b0);
        checkv("rst_code_len", 64'(bus.code_len), 64'd7);
        rst_n = 1'b1;

        // Preamble: two len-7 words then waiting in DATA
        clear_cap();
        step(1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, acc);
        repeat (15) step(1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, acc);
        checkv("pre_count", 64'(cap_bits.size()), 64'd14);
        checkv("pre_chips", q2v(cap_bits), 64'b11100101110010);
        check1("pre_busy", bus.busy, 1'b1);
        check1("pre_ready", bus.data_ready, 1'b1);

        // Table: every code select, both data polarities
        for (int i = 0; i < 8; i++) begin
            clear_cap();
            wq_sel.push_back(tab[i].sel);
            wq_din.push_back(tab[i].din);
            drive_words(1, 1'b0);
            mask = 13'((14'd1 << tab[i].len) - 14'd1);
            expv = tab[i].din ? 64'(tab[i].pat) : 64'(~tab[i].pat & mask);
            checkv($sformatf("tab%0d_chips", i), q2v(cap_bits), expv);
            checkv($sformatf("tab%0d_count", i), 64'(cap_bits.size()), 64'(tab[i].len));
            checkv($sformatf("tab%0d_code_len", i), 64'(bus.code_len), 64'(tab[i].len));
        end

        // Back-to-back len-13 words, data 1 then 0
        clear_cap();
        wq_sel.push_back(3'd6); wq_din.push_back(1'b1);
        wq_sel.push_back(3'd6); wq_din.push_back(1'b0);
        drive_words(1, 1'b0);
        checkv("b2b_count", 64'(cap_bits.size()), 64'd26);
        checkv("b2b_chips", q2v(cap_bits), 64'b11111001101010000011001010);
        checkv("b2b_first", q2v(cap_first), 64'b10000000000001000000000000);
        checkv("b2b_last", q2v(cap_last), 64'b00000000000010000000000001);
        if (cap_time.size() == 26)
            checkv("b2b_span", 64'(cap_time[25] - cap_time[0]), 64'd250);

        // Sparse en_p: len-2 code, data 0
        clear_cap();
        wq_sel.push_back(3'd0); wq_din.push_back(1'b0);
        drive_words(4, 1'b0);
        checkv("sparse_count", 64'(cap_bits.size()), 64'd2);
        checkv("sparse_chips", q2v(cap_bits), 64'b01);
        checkv("sparse_code_len", 64'(bus.code_len), 64'd2);
        if (cap_time.size() == 2)
            checkv("sparse_gap", 64'(cap_time[1] - cap_time[0]), 64'd40);

        // stop together with accept: word still sent, then IDLE
        clear_cap();
        wq_sel.push_back(3'd1); wq_din.push_back(1'b1);
        drive_words(1, 1'b1);
        checkv("stopacc_chips", q2v(cap_bits), 64'b110);
        checkv("stopacc_count", 64'(cap_bits.size()), 64'd3);
        check1("stopacc_busy", bus.busy, 1'b0);
        check1("stopacc_ready", bus.data_ready, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, acc);

        // Reset in the middle of a len-11 word
        step(1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, acc);
        repeat (15) step(1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, acc);
        clear_cap();
        step(1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, acc);
        ti = 0;
        while (cap_bits.size() < 6 && ti < 20) begin
            step(1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, acc);
            ti++;
        end
        if (ti >= 20) fail_timeout("midword_wait");
        checkv("midword_chips", q2v(cap_bits), 64'b111000);
        rst_n = 1'b0;
        #1;
        check1("arst_chip_out", bus.chip_out, 1'b0);
        check1("arst_chip_valid", bus.chip_valid, 1'b0);
        check1("arst_sym_first", bus.sym_first, 1'b0);
        check1("arst_busy", bus.busy, 1'b0);
        check1("arst_ready", bus.data_ready, 1'b0);
        checkv("arst_code_len", 64'(bus.code_len), 64'd7);
        @(posedge clk_sig);
        @(posedge clk_sig);
        #1;
        rst_n = 1'b1;
        m_reset();
        clear_cap();
        repeat (12) step(1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, acc);
        checkv("postrst_no_chips", 64'(cap_bits.size()), 64'd0);
        check1("postrst_busy", bus.busy, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 900; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 23) == 0, 3'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), acc);
        end

        // Stop during a three-word preamble: all words sent, no data phase
        bus3.en_p = 1'b1; bus3.code_sel = 3'd4; bus3.start = 1'b1;
        bus3.stop = 1'b0; bus3.data_valid = 1'b1; bus3.data_in = 1'b0;
        saw_ready = 0;
        done3 = 0;
        cap3.delete();
        for (int k = 0; k < 80 && !done3; k++) begin
            #1;
            if (bus3.data_ready) saw_ready = 1;
            @(posedge clk_sig);
            #1;
            bus3.start = 1'b0;
            bus3.stop  = (k == 4);
            if (bus3.chip_valid) cap3.push_back(bus3.chip_out);
            if (!bus3.busy) done3 = 1;
        end
        if (!done3) fail_timeout("pre3_stop");
        checkv("pre3_count", 64'(cap3.size()), 64'd21);
        checkv("pre3_chips", q2v(cap3), 64'b111001011100101110010);
        checkv("pre3_ready_seen", 64'(saw_ready), 64'd0);
        #1;
        check1("pre3_idle_ready", bus3.data_ready, 1'b0);
        check1("pre3_idle_busy", bus3.busy, 1'b0);
        $display("preamble-stop burst: %0d chips", cap3.size());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
